// File: rtl/n1_mem_arbiter_pkg.sv
// n1 memory arbiter shared types and sizes.
// Imported by the arbiter interface and the arbiter top.
package n1_mem_arbiter_pkg;

  localparam int N1_ADDR_W    = 7;
  localparam int N1_DATA_W    = 16;
  localparam int N1_HOST_WAIT = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

endpackage

// File: rtl/n1_mem_arbiter_if.sv
// Requester (cpu/host) and RAM-side bus of the n1 memory arbiter.
// slave = arbiter view, master = requesters plus RAM.
interface n1_mem_arbiter_if
  import n1_mem_arbiter_pkg::*;
();

  logic                 cpu_req;
  logic                 cpu_we;
  logic [N1_ADDR_W-1:0] cpu_addr;
  logic [N1_DATA_W-1:0] cpu_wdata;
  logic                 cpu_gnt;
  logic                 cpu_rvalid;

  logic                 host_req;
  logic                 host_we;
  logic [N1_ADDR_W-1:0] host_addr;
  logic [N1_DATA_W-1:0] host_wdata;
  logic                 host_gnt;
  logic                 host_rvalid;

  logic [N1_DATA_W-1:0] rdata;

  logic                 mem_en;
  logic                 mem_we;
  logic [N1_ADDR_W-1:0] mem_addr;
  logic [N1_DATA_W-1:0] mem_wdata;
  logic [N1_DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/n1_mem_arbiter.sv
// Single-port RAM arbiter: host-only BOOT/HALT, CPU-priority RUN
// with a host starvation guard, 1-cycle read return to owner.
module n1_mem_arbiter
  import n1_mem_arbiter_pkg::*;
#(
  parameter int HOST_WAIT = N1_HOST_WAIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             boot_done,
  input  logic             halt_req,
  output logic [1:0]       state_o,
  n1_mem_arbiter_if.slave  bus
);

  localparam int WCW = $clog2(HOST_WAIT + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(HOST_WAIT);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [WCW-1:0]       r_wait_cnt;
  logic [WCW-1:0]       w_wait_nxt;
  owner_t               r_rd_owner;
  owner_t               w_owner_nxt;
  logic [N1_DATA_W-1:0] r_rdata;
  logic                 w_cpu_gnt;
  logic                 w_host_gnt;
  logic                 w_host_due;

  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_host_gnt  = 1'b0;
    w_state_nxt = r_state;
    w_wait_nxt  = '0;
    w_owner_nxt = OWN_NONE;
    w_host_due  = bus.host_req && (r_wait_cnt == WMAX);
    case (r_state)
      ST_RUN: begin
        if (w_host_due)        w_host_gnt = 1'b1;
        else if (bus.cpu_req)  w_cpu_gnt  = 1'b1;
        else if (bus.host_req) w_host_gnt = 1'b1;
        if (halt_req) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        w_host_gnt = bus.host_req;
        if (!halt_req) w_state_nxt = ST_RUN;
      end
      default: begin
        w_host_gnt = bus.host_req;
        if (boot_done) w_state_nxt = ST_RUN;
      end
    endcase
    // Counter only lives while RUN persists; any exit clears it
    if (r_state == ST_RUN && w_state_nxt == ST_RUN &&
        bus.host_req && !w_host_gnt)
      w_wait_nxt = (r_wait_cnt == WMAX) ? r_wait_cnt
                                        : r_wait_cnt + 1'b1;
    if (w_cpu_gnt && !bus.cpu_we)        w_owner_nxt = OWN_CPU;
    else if (w_host_gnt && !bus.host_we) w_owner_nxt = OWN_HOST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_wait_cnt <= '0;
      r_rd_owner <= OWN_NONE;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_rd_owner <= w_owner_nxt;
      if (r_rd_owner != OWN_NONE) r_rdata <= bus.mem_rdata;
    end
  end

  assign bus.cpu_gnt     = w_cpu_gnt;
  assign bus.host_gnt    = w_host_gnt;
  assign bus.cpu_rvalid  = (r_rd_owner == OWN_CPU);
  assign bus.host_rvalid = (r_rd_owner == OWN_HOST);
  // Pass RAM data through on return, else hold the last returned word
  assign bus.rdata = (r_rd_owner != OWN_NONE) ? bus.mem_rdata
                                              : r_rdata;

  assign bus.mem_en    = w_cpu_gnt | w_host_gnt;
  assign bus.mem_we    = w_cpu_gnt  ? bus.cpu_we    :
                         w_host_gnt ? bus.host_we   : 1'b0;
  assign bus.mem_addr  = w_cpu_gnt  ? bus.cpu_addr  :
                         w_host_gnt ? bus.host_addr : '0;
  assign bus.mem_wdata = w_cpu_gnt  ? bus.cpu_wdata  :
                         w_host_gnt ? bus.host_wdata : '0;

  assign state_o = r_state;

endmodule

// File: tb/tb_n1_mem_arbiter.sv
// Directed bench for n1_mem_arbiter with a write-first
// registered-read RAM model behind the arbiter.
module tb_n1_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       boot_done;
  logic       halt_req;
  logic [1:0] state_o;
  int         errors = 0;
  int         checks = 0;

  n1_mem_arbiter_if bus();

  n1_mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .boot_done (boot_done),
    .halt_req  (halt_req),
    .state_o   (state_o),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [128];
  logic [15:0] ram_q;

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 16'h0000;
    ram_q = 16'h0000;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        ram_q <= bus.mem_wdata;
      end else begin
        ram_q <= ram[bus.mem_addr];
      end
    end
  end

  assign bus.mem_rdata = ram_q;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (state_o !== 2'd0) begin
      errors++;
      $display("FAIL rst_state got=%0d exp=0", state_o);
    end
    checks++;
    if (bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mem_en got=%b exp=0", bus.mem_en);
    end
    checks++;
    if ({bus.cpu_rvalid, bus.host_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rst_rvalid got=%b%b exp=00",
               bus.cpu_rvalid, bus.host_rvalid);
    end
    checks++;
    if (bus.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL rst_rdata got=%h exp=0000", bus.rdata);
    end
  endtask

  task automatic test_boot;
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 7'h05;
    for (int i = 0; i < 10; i++) begin
      bus.host_req   = (i == 3) || (i == 6);
      bus.host_we    = 1'b1;
      bus.host_addr  = (i == 3) ? 7'h05 : 7'h10;
      bus.host_wdata = (i == 3) ? 16'h1234 : 16'h0A55;
      @(negedge clk);
      checks++;
      if (bus.cpu_gnt !== 1'b0) begin
        errors++;
        $display("FAIL boot_cpu_gnt cyc=%0d got=%b exp=0",
                 i, bus.cpu_gnt);
      end
      if (i == 3) begin
        checks++;
        if ({bus.host_gnt, bus.mem_we} !== 2'b11) begin
          errors++;
          $display("FAIL boot_host_gnt_we got=%b%b exp=11",
                   bus.host_gnt, bus.mem_we);
        end
        checks++;
        if (bus.mem_addr !== 7'h05 || bus.mem_wdata !== 16'h1234) begin
          errors++;
          $display("FAIL boot_wr got=%h/%h exp=05/1234",
                   bus.mem_addr, bus.mem_wdata);
        end
      end
      tick();
    end
    idle_reqs();
  endtask

  task automatic test_run_read;
    boot_done = 1'b1;
    @(negedge clk);
    checks++;
    if (state_o !== 2'd0) begin
      errors++;
      $display("FAIL bd_state got=%0d exp=0", state_o);
    end
    tick();
    boot_done    = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 7'h05;
    @(negedge clk);
    checks++;
    if (state_o !== 2'd1) begin
      errors++;
      $display("FAIL run_state got=%0d exp=1", state_o);
    end
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL run_cpu_gnt got=%b exp=1", bus.cpu_gnt);
    end
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cpu_rvalid, bus.host_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL run_rvalid got=%b%b exp=10",
               bus.cpu_rvalid, bus.host_rvalid);
    end
    checks++;
    if (bus.rdata !== 16'h1234) begin
      errors++;
      $display("FAIL run_rdata got=%h exp=1234", bus.rdata);
    end
    tick();
  endtask

  task automatic test_starve;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 7'h00;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 7'h10;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.host_gnt !== (k == 5) || bus.cpu_gnt !== (k != 5)) begin
        errors++;
        $display("FAIL starve_gnt cyc=%0d got=h%b c%b exp=h%b c%b",
                 k, bus.host_gnt, bus.cpu_gnt, k == 5, k != 5);
      end
      tick();
    end
    bus.host_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.host_rvalid, bus.cpu_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL starve_rvalid got=h%b c%b exp=h1 c0",
               bus.host_rvalid, bus.cpu_rvalid);
    end
    checks++;
    if (bus.rdata !== 16'h0A55) begin
      errors++;
      $display("FAIL starve_rdata got=%h exp=0a55", bus.rdata);
    end
    checks++;
    if (dut.r_wait_cnt !== 3'd0) begin
      errors++;
      $display("FAIL starve_wait_cnt got=%0d exp=0", dut.r_wait_cnt);
    end
    tick();
  endtask

  task automatic test_halt;
    halt_req = 1'b1;
    @(negedge clk);
    checks++;
    if (state_o !== 2'd1 || bus.cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL halt_enter got=s%0d g%b exp=s1 g1",
               state_o, bus.cpu_gnt);
    end
    tick();
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 7'h05;
    @(negedge clk);
    checks++;
    if (state_o !== 2'd2) begin
      errors++;
      $display("FAIL halt_state got=%0d exp=2", state_o);
    end
    checks++;
    if ({bus.cpu_gnt, bus.host_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL halt_gnt got=c%b h%b exp=c0 h1",
               bus.cpu_gnt, bus.host_gnt);
    end
    tick();
    bus.host_req = 1'b0;
    halt_req     = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 2'd2 || bus.cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL halt_exit_cyc got=s%0d g%b exp=s2 g0",
               state_o, bus.cpu_gnt);
    end
    checks++;
    if (bus.host_rvalid !== 1'b1 || bus.rdata !== 16'h1234) begin
      errors++;
      $display("FAIL halt_rd got=v%b d%h exp=v1 d1234",
               bus.host_rvalid, bus.rdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (state_o !== 2'd1 || bus.cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL halt_resume got=s%0d g%b exp=s1 g1",
               state_o, bus.cpu_gnt);
    end
    tick();
    idle_reqs();
  endtask

  task automatic test_back_to_back;
    logic [15:0] d [2];
    d[0] = 16'hBEEF;
    d[1] = 16'hCAFE;
    for (int p = 0; p < 2; p++) begin
      bus.host_req  = 1'b0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 7'h7F;
      bus.cpu_wdata = d[p];
      @(negedge clk);
      checks++;
      if (bus.cpu_gnt !== 1'b1 || bus.mem_we !== 1'b1 ||
          bus.mem_wdata !== d[p]) begin
        errors++;
        $display("FAIL b2b_wr p=%0d got=g%b w%b d%h exp=g1 w1 d%h",
                 p, bus.cpu_gnt, bus.mem_we, bus.mem_wdata, d[p]);
      end
      if (p > 0) begin
        checks++;
        if (bus.host_rvalid !== 1'b1 || bus.rdata !== d[p-1]) begin
          errors++;
          $display("FAIL b2b_rd p=%0d got=v%b d%h exp=v1 d%h",
                   p, bus.host_rvalid, bus.rdata, d[p-1]);
        end
      end
      tick();
      bus.cpu_req   = 1'b0;
      bus.host_req  = 1'b1;
      bus.host_we   = 1'b0;
      bus.host_addr = 7'h7F;
      @(negedge clk);
      checks++;
      if (bus.host_gnt !== 1'b1 || bus.mem_en !== 1'b1 ||
          bus.cpu_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hgnt p=%0d got=g%b e%b cv%b exp=g1 e1 cv0",
                 p, bus.host_gnt, bus.mem_en, bus.cpu_rvalid);
      end
      tick();
    end
    idle_reqs();
    @(negedge clk);
    checks++;
    if (bus.host_rvalid !== 1'b1 || bus.rdata !== 16'hCAFE) begin
      errors++;
      $display("FAIL b2b_last got=v%b d%h exp=v1 dcafe",
               bus.host_rvalid, bus.rdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.host_rvalid !== 1'b0 || bus.rdata !== 16'hCAFE) begin
      errors++;
      $display("FAIL b2b_hold got=v%b d%h exp=v0 dcafe",
               bus.host_rvalid, bus.rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 7'h7F;
    @(negedge clk);
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rmid_gnt got=%b exp=1", bus.cpu_gnt);
    end
    tick();
    idle_reqs();
    checks++;
    if (bus.cpu_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got=%b exp=1", bus.cpu_rvalid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cpu_rvalid !== 1'b0 || state_o !== 2'd0 ||
        bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async got=v%b s%0d e%b exp=v0 s0 e0",
               bus.cpu_rvalid, state_o, bus.mem_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_en !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rmid_post cyc=%0d got=e%b v%b exp=e0 v0",
                 i, bus.mem_en, bus.cpu_rvalid);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    boot_done = 1'b0;
    halt_req  = 1'b0;
    idle_reqs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_boot();
    test_run_read();
    test_starve();
    test_halt();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
